// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
//   Shares one 8-entry register file between two requesters (A and B) with
//   round-robin arbitration. Each grant carries exactly one operation, read
//   or write, through a three-state sequence:
//     IDLE -> ACCESS -> RESP -> (ACCESS | IDLE)
//   Every output is decoded from the state and the latched operation, so there
//   is no combinational path from a request to the register file ports.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active-low
//   req_a / req_b       operation request
//   we_a / we_b         1 = write, 0 = read (valid with req)
//   addr_a / addr_b     register address (valid with req)
//   wdata_a / wdata_b   write data (valid with req)
//   gnt_a / gnt_b       high during the ACCESS cycle of the served requester
//   done_a / done_b     one-cycle completion pulse (RESP cycle)
//   rdata_a / rdata_b   read result, valid with done and held afterwards
//   rf_read_enable, rf_write_enable, rf_read_addr, rf_write_addr,
//   rf_write_data       register file controls (zero outside ACCESS)
//   rf_read_data        register file read data (valid after the ACCESS negedge)
//
// Configuration
//   RFARB_R0_PROTECT_EN  when defined, register 0 is read-only: a write to
//                        address 0 is granted and completes, but
//                        rf_write_enable stays low for it.
module regfile_access_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             we_a,
  input  logic             we_b,
  input  logic [2:0]       addr_a,
  input  logic [2:0]       addr_b,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rf_read_enable,
  output logic             rf_write_enable,
  output logic [2:0]       rf_read_addr,
  output logic [2:0]       rf_write_addr,
  output logic [WIDTH-1:0] rf_write_data,
  input  logic [WIDTH-1:0] rf_read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_b;   // 1 = last grant went to B
  logic             r_sel_b;    // requester served by the current op
  logic             r_we;
  logic [2:0]       r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;
  logic             w_arb_go;
  logic             w_pick_b;
  logic             w_wr_ok;

  // B wins only when A is idle or when A was the last one served.
  always_comb begin
    w_pick_b = req_b & (~req_a | ~r_last_b);
    w_arb_go = ((r_state == S_IDLE) || (r_state == S_RESP)) && (req_a || req_b);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_arb_go) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = w_arb_go ? S_ACCESS : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_last_b <= 1'b1;
      r_sel_b  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_arb_go) begin
        r_sel_b  <= w_pick_b;
        r_last_b <= w_pick_b;
      end
    end
  end

  // Operation fields are only consumed during ACCESS, which always follows a
  // load, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_arb_go) begin
      r_we    <= w_pick_b ? we_b    : we_a;
      r_addr  <= w_pick_b ? addr_b  : addr_a;
      r_wdata <= w_pick_b ? wdata_b : wdata_a;
    end
  end

  // The register file presents read data at the ACCESS negedge; take it at the
  // closing posedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else if ((r_state == S_ACCESS) && !r_we) begin
      if (r_sel_b) r_rdata_b <= rf_read_data;
      else         r_rdata_a <= rf_read_data;
    end
  end

`ifdef RFARB_R0_PROTECT_EN
  always_comb w_wr_ok = (r_addr != 3'd0);
`else
  always_comb w_wr_ok = 1'b1;
`endif

  always_comb begin
    gnt_a           = 1'b0;
    gnt_b           = 1'b0;
    done_a          = 1'b0;
    done_b          = 1'b0;
    rf_read_enable  = 1'b0;
    rf_write_enable = 1'b0;
    rf_read_addr    = 3'd0;
    rf_write_addr   = 3'd0;
    rf_write_data   = '0;
    if (r_state == S_ACCESS) begin
      gnt_a = ~r_sel_b;
      gnt_b = r_sel_b;
      if (r_we) begin
        rf_write_enable = w_wr_ok;
        rf_write_addr   = r_addr;
        rf_write_data   = r_wdata;
      end else begin
        rf_read_enable = 1'b1;
        rf_read_addr   = r_addr;
      end
    end else if (r_state == S_RESP) begin
      done_a = ~r_sel_b;
      done_b = r_sel_b;
    end
  end

  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;

endmodule
